// File: rtl/bht_pkg.sv
// Shared types, defaults and width helpers for the BHT update scheduler.
package bht_pkg;

  localparam int unsigned DEF_ADDR_WIDTH    = 32;
  localparam int unsigned DEF_HISTORY_DEPTH = 512;

  function automatic int unsigned log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned h_addr_width(input int unsigned depth);
    return log2(depth);
  endfunction

  function automatic int unsigned tag_width(input int unsigned aw, input int unsigned depth);
    return aw - log2(depth) - 2;
  endfunction

  localparam int unsigned DEF_H_ADDR_WIDTH = h_addr_width(DEF_HISTORY_DEPTH);
  localparam int unsigned DEF_TAG_WIDTH    = tag_width(DEF_ADDR_WIDTH, DEF_HISTORY_DEPTH);

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] pc;
    logic [DEF_ADDR_WIDTH-1:0] target;
    logic                      taken;
    logic                      is_return;
  } bht_upd_t;

  typedef enum logic [1:0] {
    ST_SWEEP = 2'd0,
    ST_IDLE  = 2'd1,
    ST_DRAIN = 2'd2
  } bht_state_e;

endpackage

// File: rtl/bht_upd_fifo.sv
// Generic synchronous FIFO with count/full/empty and a synchronous clear.
module bht_upd_fifo
  import bht_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = log2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push && !i_clr) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/bht_update_scheduler.sv
// Queues resolved-branch updates toward the BHT write port and sequences full-table sweeps.
// Optional statistics counters are enabled by defining BHT_UPD_STATS_EN.
module bht_update_scheduler
  import bht_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int unsigned HISTORY_DEPTH = DEF_HISTORY_DEPTH,
  parameter int unsigned QUEUE_DEPTH   = 4,
  localparam int unsigned H_ADDR_WIDTH = h_addr_width(HISTORY_DEPTH),
  localparam int unsigned TAG_WIDTH    = tag_width(ADDR_WIDTH, HISTORY_DEPTH)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CACHE_READY,
  input  logic                    UPD_VALID,
  output logic                    UPD_READY,
  input  logic [ADDR_WIDTH-1:0]   UPD_PC,
  input  logic [ADDR_WIDTH-1:0]   UPD_TARGET,
  input  logic                    UPD_TAKEN,
  input  logic                    UPD_RETURN,
  input  logic                    INV_REQ,
  output logic                    INV_BUSY,
  output logic                    BHT_WR_EN,
  output logic                    BHT_WR_CLEAR,
  output logic [H_ADDR_WIDTH-1:0] BHT_WR_IDX,
  output logic [TAG_WIDTH-1:0]    BHT_WR_TAG,
  output logic [ADDR_WIDTH-1:0]   BHT_WR_TARGET,
  output logic                    BHT_WR_TAKEN,
  output logic                    BHT_WR_RETURN
`ifdef BHT_UPD_STATS_EN
  ,
  output logic [31:0]             STAT_UPDATES,
  output logic [31:0]             STAT_DISCARDS,
  output logic [31:0]             STAT_STALLS
`endif
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] target;
    logic                  taken;
    logic                  is_return;
  } upd_rec_t;

  localparam int unsigned CW = log2(QUEUE_DEPTH) + 1;

  bht_state_e            r_state;
  logic [H_ADDR_WIDTH-1:0] r_sweep_idx;
  upd_rec_t              w_din;
  upd_rec_t              w_head;
  logic [CW-1:0]         w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_xfer;
  logic                  w_pop;
  logic                  w_flush;
  logic                  w_sweep_wr;
  logic                  w_unused;

  assign w_din      = '{pc: UPD_PC, target: UPD_TARGET, taken: UPD_TAKEN, is_return: UPD_RETURN};
  assign UPD_READY  = (r_state != ST_SWEEP) & ~w_full;
  assign INV_BUSY   = (r_state == ST_SWEEP);
  assign w_xfer     = UPD_VALID & UPD_READY;
  assign w_pop      = (r_state == ST_DRAIN) & ~w_empty & CACHE_READY & ~RST;
  assign w_flush    = INV_REQ & (r_state != ST_SWEEP);
  assign w_sweep_wr = (r_state == ST_SWEEP) & CACHE_READY & ~RST;
  assign w_unused   = ^w_head.pc[1:0];

  // Clear wins over push inside the FIFO, so a same-cycle transfer is dropped.
  bht_upd_fifo #(
    .WIDTH ($bits(upd_rec_t)),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_clr   (w_flush),
    .i_push  (w_xfer),
    .i_pop   (w_pop),
    .i_din   (w_din),
    .o_dout  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    BHT_WR_EN     = w_sweep_wr | w_pop;
    BHT_WR_CLEAR  = w_sweep_wr;
    BHT_WR_IDX    = '0;
    BHT_WR_TAG    = '0;
    BHT_WR_TARGET = '0;
    BHT_WR_TAKEN  = 1'b0;
    BHT_WR_RETURN = 1'b0;
    if (RST) begin
      BHT_WR_IDX = '0;
    end else if (r_state == ST_SWEEP) begin
      BHT_WR_IDX = r_sweep_idx;
    end else if (w_pop) begin
      BHT_WR_IDX    = w_head.pc[H_ADDR_WIDTH+1:2];
      BHT_WR_TAG    = w_head.pc[ADDR_WIDTH-1:H_ADDR_WIDTH+2];
      BHT_WR_TARGET = w_head.target;
      BHT_WR_TAKEN  = w_head.taken;
      BHT_WR_RETURN = w_head.is_return;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= ST_SWEEP;
      r_sweep_idx <= '0;
    end else begin
      case (r_state)
        ST_SWEEP: begin
          if (INV_REQ) begin
            r_sweep_idx <= '0;
          end else if (CACHE_READY) begin
            if (r_sweep_idx == H_ADDR_WIDTH'(HISTORY_DEPTH - 1)) begin
              r_sweep_idx <= '0;
              r_state     <= ST_IDLE;
            end else begin
              r_sweep_idx <= r_sweep_idx + 1'b1;
            end
          end
        end
        ST_IDLE: begin
          if (INV_REQ) begin
            r_state     <= ST_SWEEP;
            r_sweep_idx <= '0;
          end else if (w_xfer) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (INV_REQ) begin
            r_state     <= ST_SWEEP;
            r_sweep_idx <= '0;
          end else if (w_pop && !w_xfer && (w_count == CW'(1))) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_SWEEP;
          r_sweep_idx <= '0;
        end
      endcase
    end
  end

`ifdef BHT_UPD_STATS_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      STAT_UPDATES  <= '0;
      STAT_DISCARDS <= '0;
      STAT_STALLS   <= '0;
    end else begin
      if (w_xfer) STAT_UPDATES <= STAT_UPDATES + 32'd1;
      if (UPD_VALID && !UPD_READY) STAT_STALLS <= STAT_STALLS + 32'd1;
      // Entries still queued after this cycle's pop, plus the transfer being dropped.
      if (w_flush)
        STAT_DISCARDS <= STAT_DISCARDS + 32'(w_count) - 32'(w_pop) + 32'(w_xfer);
    end
  end
`endif

endmodule

// File: tb/tb_bht_update_scheduler.sv
// Directed bench for bht_update_scheduler: queue-based reference model plus literal checks.
module tb_bht_update_scheduler;

  localparam int unsigned AW = 32;
  localparam int unsigned HD = 8;
  localparam int unsigned QD = 4;
  localparam int unsigned HW = 3;
  localparam int unsigned TW = AW - HW - 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          CACHE_READY = 1'b1;
  logic          UPD_VALID = 1'b0;
  logic          UPD_READY;
  logic [AW-1:0] UPD_PC = '0;
  logic [AW-1:0] UPD_TARGET = '0;
  logic          UPD_TAKEN = 1'b0;
  logic          UPD_RETURN = 1'b0;
  logic          INV_REQ = 1'b0;
  logic          INV_BUSY;
  logic          BHT_WR_EN;
  logic          BHT_WR_CLEAR;
  logic [HW-1:0] BHT_WR_IDX;
  logic [TW-1:0] BHT_WR_TAG;
  logic [AW-1:0] BHT_WR_TARGET;
  logic          BHT_WR_TAKEN;
  logic          BHT_WR_RETURN;
`ifdef BHT_UPD_STATS_EN
  logic [31:0]   STAT_UPDATES;
  logic [31:0]   STAT_DISCARDS;
  logic [31:0]   STAT_STALLS;
`endif

  int errors = 0;
  int checks = 0;

  bht_update_scheduler #(
    .ADDR_WIDTH    (AW),
    .HISTORY_DEPTH (HD),
    .QUEUE_DEPTH   (QD)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .CACHE_READY   (CACHE_READY),
    .UPD_VALID     (UPD_VALID),
    .UPD_READY     (UPD_READY),
    .UPD_PC        (UPD_PC),
    .UPD_TARGET    (UPD_TARGET),
    .UPD_TAKEN     (UPD_TAKEN),
    .UPD_RETURN    (UPD_RETURN),
    .INV_REQ       (INV_REQ),
    .INV_BUSY      (INV_BUSY),
    .BHT_WR_EN     (BHT_WR_EN),
    .BHT_WR_CLEAR  (BHT_WR_CLEAR),
    .BHT_WR_IDX    (BHT_WR_IDX),
    .BHT_WR_TAG    (BHT_WR_TAG),
    .BHT_WR_TARGET (BHT_WR_TARGET),
    .BHT_WR_TAKEN  (BHT_WR_TAKEN),
    .BHT_WR_RETURN (BHT_WR_RETURN)
`ifdef BHT_UPD_STATS_EN
    ,
    .STAT_UPDATES  (STAT_UPDATES),
    .STAT_DISCARDS (STAT_DISCARDS),
    .STAT_STALLS   (STAT_STALLS)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a queue of pending updates and a sweep cursor.
  typedef struct {
    logic [AW-1:0] pc;
    logic [AW-1:0] target;
    logic          taken;
    logic          ret;
  } upd_t;

  upd_t        m_q[$];
  bit          m_sweeping;
  int unsigned m_sidx;
  int unsigned m_updates, m_discards, m_stalls;

  always @(negedge CLK) begin
    bit          e_ready, e_en, e_clr, e_taken, e_ret, push, popped;
    logic [63:0] e_idx, e_tag, e_tgt;
    upd_t        u;
    if (RST) begin
      m_q.delete();
      m_sweeping = 1'b1;
      m_sidx = 0;
      m_updates = 0; m_discards = 0; m_stalls = 0;
      chk("rst_en", BHT_WR_EN, 0);
      chk("rst_clear", BHT_WR_CLEAR, 0);
      chk("rst_idx", BHT_WR_IDX, 0);
      chk("rst_ready", UPD_READY, 0);
      chk("rst_busy", INV_BUSY, 1);
`ifdef BHT_UPD_STATS_EN
      chk("rst_stats", {STAT_UPDATES, STAT_DISCARDS ^ STAT_STALLS}, 0);
`endif
    end else begin
      e_ready = !m_sweeping && (m_q.size() < QD);
      e_en = 0; e_clr = 0; e_idx = 0; e_tag = 0; e_tgt = 0; e_taken = 0; e_ret = 0;
      if (m_sweeping) begin
        e_en = CACHE_READY; e_clr = CACHE_READY; e_idx = 64'(m_sidx);
      end else if (m_q.size() > 0 && CACHE_READY) begin
        u = m_q[0];
        e_en = 1; e_idx = 64'((u.pc >> 2) % HD); e_tag = 64'(u.pc >> (HW + 2));
        e_tgt = 64'(u.target); e_taken = u.taken; e_ret = u.ret;
      end
      chk("m_busy", INV_BUSY, 64'(m_sweeping));
      chk("m_ready", UPD_READY, 64'(e_ready));
      chk("m_en", BHT_WR_EN, 64'(e_en));
      chk("m_clear", BHT_WR_CLEAR, 64'(e_clr));
      chk("m_idx", BHT_WR_IDX, e_idx);
      chk("m_tag", BHT_WR_TAG, e_tag);
      chk("m_target", BHT_WR_TARGET, e_tgt);
      chk("m_taken", BHT_WR_TAKEN, 64'(e_taken));
      chk("m_return", BHT_WR_RETURN, 64'(e_ret));
`ifdef BHT_UPD_STATS_EN
      chk("m_stat_upd", STAT_UPDATES, 64'(m_updates));
      chk("m_stat_disc", STAT_DISCARDS, 64'(m_discards));
      chk("m_stat_stall", STAT_STALLS, 64'(m_stalls));
`endif
      push = UPD_VALID && e_ready;
      if (UPD_VALID && !e_ready) m_stalls++;
      if (push) m_updates++;
      if (m_sweeping) begin
        if (INV_REQ) m_sidx = 0;
        else if (CACHE_READY) begin
          if (m_sidx == HD - 1) begin m_sidx = 0; m_sweeping = 0; end
          else m_sidx++;
        end
      end else begin
        popped = (m_q.size() > 0) && CACHE_READY;
        if (popped) void'(m_q.pop_front());
        if (INV_REQ) begin
          m_discards += m_q.size() + int'(push);
          m_q.delete();
          m_sweeping = 1;
          m_sidx = 0;
        end else if (push) begin
          u.pc = UPD_PC; u.target = UPD_TARGET; u.taken = UPD_TAKEN; u.ret = UPD_RETURN;
          m_q.push_back(u);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic offer(input logic [AW-1:0] pc, input logic [AW-1:0] tgt,
                       input logic tk, input logic rt);
    UPD_VALID = 1; UPD_PC = pc; UPD_TARGET = tgt; UPD_TAKEN = tk; UPD_RETURN = rt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset release: eight consecutive CLEAR writes, then ready.
    repeat (3) step();
    RST = 0;
    for (int i = 0; i < HD; i++) begin
      @(negedge CLK);
      chk("sweep_en", {BHT_WR_EN, BHT_WR_CLEAR}, 2'b11);
      chk("sweep_idx", BHT_WR_IDX, 64'(i));
    end
    @(negedge CLK);
    chk("sweep_done_busy", INV_BUSY, 0);
    chk("sweep_done_ready", UPD_READY, 1);

    // Single update written on the following cycle.
    step();
    offer(32'h0000_1004, 32'h0000_2000, 1, 0);
    step();
    UPD_VALID = 0;
    @(negedge CLK);
    chk("upd_en", {BHT_WR_EN, BHT_WR_CLEAR}, 2'b10);
    chk("upd_idx", BHT_WR_IDX, 1);
    chk("upd_tag", BHT_WR_TAG, 64'h80);
    chk("upd_target", BHT_WR_TARGET, 64'h2000);
    chk("upd_taken", BHT_WR_TAKEN, 1);

    // Fill while stalled, then drain in order.
    step();
    CACHE_READY = 0;
    for (int i = 0; i < 4; i++) begin
      offer(32'h0000_0100 + 32'(i * 4), 32'h0000_A000 + 32'(i), 1'(i % 2), 1'(i == 3));
      step();
    end
    offer(32'h0000_0200, 32'h0000_B000, 0, 1);
    @(negedge CLK);
    chk("full_ready", UPD_READY, 0);
    step();
    CACHE_READY = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("drain_en", BHT_WR_EN, 1);
      chk("drain_target", BHT_WR_TARGET, (i < 4) ? 64'h0000_A000 + 64'(i) : 64'h0000_B000);
      if (i == 0) chk("ready_before_pop", UPD_READY, 0);
      if (i == 1) chk("ready_after_pop", UPD_READY, 1);
      step();
      if (i == 1) UPD_VALID = 0;
    end

    // Invalidate with three queued entries plus a same-cycle push.
    CACHE_READY = 0;
    for (int i = 0; i < 3; i++) begin
      offer(32'h0000_0300 + 32'(i * 4), 32'h0000_C000 + 32'(i), 1, 0);
      step();
    end
    offer(32'h0000_0400, 32'h0000_D000, 1, 0);
    INV_REQ = 1;
    @(negedge CLK);
    chk("inv_no_write", BHT_WR_EN, 0);
    step();
    UPD_VALID = 0;
    INV_REQ = 0;
    @(negedge CLK);
    chk("inv_busy", INV_BUSY, 1);
    chk("inv_idx", BHT_WR_IDX, 0);
`ifdef BHT_UPD_STATS_EN
    chk("inv_discards", STAT_DISCARDS, 4);
`endif

    // Sweep with CACHE_READY toggling; indices advance only on enabled cycles.
    begin
      int k = 0;
      for (int c = 0; c < 8; c++) begin
        step();
        CACHE_READY = (c % 2 == 0);
        @(negedge CLK);
        chk("toggle_en", BHT_WR_EN, 64'(CACHE_READY));
        chk("toggle_idx", BHT_WR_IDX, 64'(k));
        if (CACHE_READY) k++;
      end
    end
    step();
    CACHE_READY = 1;
    INV_REQ = 1;
    @(negedge CLK);
    chk("restart_fire_idx", BHT_WR_IDX, 4);
    step();
    INV_REQ = 0;
    for (int i = 0; i < HD; i++) begin
      @(negedge CLK);
      chk("restart_idx", BHT_WR_IDX, 64'(i));
      step();
    end
    @(negedge CLK);
    chk("restart_done", INV_BUSY, 0);

    // Asynchronous reset in the middle of a drain.
    step();
    CACHE_READY = 0;
    offer(32'h0000_0500, 32'h0000_E000, 1, 0);
    step();
    offer(32'h0000_0504, 32'h0000_E004, 0, 0);
    step();
    UPD_VALID = 0;
    CACHE_READY = 1;
    @(negedge CLK);
    chk("middrain_en", BHT_WR_EN, 1);
    @(posedge CLK);
    #3;
    RST = 1;
    #1;
    chk("async_en", BHT_WR_EN, 0);
    chk("async_busy", INV_BUSY, 1);
    chk("async_ready", UPD_READY, 0);
    step();
    RST = 0;
    for (int i = 0; i < HD; i++) begin
      @(negedge CLK);
      chk("post_rst_idx", {BHT_WR_CLEAR, BHT_WR_IDX}, {1'b1, 3'(i)});
      step();
    end
    repeat (3) step();
    @(negedge CLK);
    chk("final_ready", UPD_READY, 1);
    chk("final_idle_en", BHT_WR_EN, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bht_update_scheduler.md
Name: bht_update_scheduler

Overview:
- Sits between the EX-stage branch-resolution path and the branch history table (BHT) write port.
- Buffers resolved-branch updates in a small FIFO and drains one update per cycle, but only on cycles where the cache is not stalling.
- Also sequences a full-table invalidation sweep, triggered by reset or by a fence/flush request; update writes are locked out while the sweep runs.

Parameters:
- ADDR_WIDTH, 32, PC/target width.
- HISTORY_DEPTH, 512, number of BHT entries; power of two.
- QUEUE_DEPTH, 4, update FIFO depth; power of two, >=2.
- Derived localparams: H_ADDR_WIDTH = log2(HISTORY_DEPTH); TAG_WIDTH = ADDR_WIDTH - H_ADDR_WIDTH - 2.

Ports:
- CLK  in  1  clock
- RST  in  1  reset; asynchronous, active-high
- CACHE_READY  in  1  pipeline advance enable; BHT writes occur only when high
- UPD_VALID  in  1  EX offers a resolved branch
- UPD_READY  out  1  FIFO can accept this cycle
- UPD_PC  in  ADDR_WIDTH  branch PC
- UPD_TARGET  in  ADDR_WIDTH  resolved target
- UPD_TAKEN  in  1  branch outcome
- UPD_RETURN  in  1  branch is a return
- INV_REQ  in  1  single-cycle pulse requesting a full-table invalidation
- INV_BUSY  out  1  sweep in progress
- BHT_WR_EN  out  1  write strobe to BHT
- BHT_WR_CLEAR  out  1  with WR_EN: invalidate entry (state=0, history=2'b01)
- BHT_WR_IDX  out  H_ADDR_WIDTH  entry index, taken from PC[H_ADDR_WIDTH+1:2]
- BHT_WR_TAG  out  TAG_WIDTH  taken from PC[ADDR_WIDTH-1:H_ADDR_WIDTH+2]
- BHT_WR_TARGET  out  ADDR_WIDTH  target
- BHT_WR_TAKEN  out  1  outcome, used by the BHT to step its 2-bit counter
- BHT_WR_RETURN  out  1  return flag

Behaviour:
- Reset:
  - Outputs: BHT_WR_* = 0, UPD_READY = 0, INV_BUSY = 1.
  - FIFO pointers and count = 0; FSM = SWEEP with sweep index = 0. Every reset therefore invalidates the whole table.
- FSM states: SWEEP, IDLE, DRAIN.
- SWEEP:
  - Outputs: BHT_WR_EN = 1 and BHT_WR_CLEAR = 1 only when CACHE_READY is high; BHT_WR_IDX = sweep index.
  - The sweep index increments only on cycles where the write fires (CACHE_READY high).
  - After the write at index HISTORY_DEPTH-1, the index wraps to 0 and the FSM goes to IDLE.
  - INV_BUSY = 1 and UPD_READY = 0 throughout.
  - The sweep takes exactly HISTORY_DEPTH enabled cycles.
- IDLE: FIFO empty. Accepting an update moves the FSM to DRAIN on the next cycle.
- DRAIN:
  - When the FIFO is non-empty and CACHE_READY is high, pop the head and drive BHT_WR_EN = 1 with BHT_WR_CLEAR = 0 and the head's fields.
  - Return to IDLE when the count reaches 0 after a pop with no concurrent push.
- Handshake:
  - UPD_READY = (count < QUEUE_DEPTH) and not in SWEEP. It is registered-state based, with no combinational path from UPD_VALID.
  - Transfer happens when UPD_VALID & UPD_READY; fields are captured in that cycle.
  - The producer holds UPD_VALID and its fields while UPD_READY is low.
- Latency: an update accepted in cycle N is written no earlier than N+1. FIFO order is preserved, so two updates to the same index are written oldest first.
- Full FIFO with a pop in the same cycle: UPD_READY stays 0, because readiness is based on the pre-pop count. No bypass.
- Empty FIFO with a push in the same cycle: no same-cycle write.
- Push and pop in the same cycle: count is unchanged.
- Pointers are QUEUE_DEPTH-modulo and wrap naturally.
- CACHE_READY low: no write and no pop, but a push is still accepted if UPD_READY is high.
- INV_REQ while in IDLE or DRAIN:
  - FIFO is discarded (count = 0, pointers reset) and the FSM enters SWEEP on the next cycle.
  - An update transferring in the same cycle as INV_REQ is discarded.
  - Any pop write in that cycle still completes.
- INV_REQ while in SWEEP: the sweep index restarts at 0.
- RST asserted mid-sweep or mid-drain: asynchronous return to the reset state.
- BHT_WR_* are combinational from registered state and CACHE_READY. The BHT samples them on the CLK edge.

Optional Feature:
- Macro: BHT_UPD_STATS_EN.
- When defined:
  - Adds 32-bit output counters STAT_UPDATES (accepted pushes), STAT_DISCARDS (entries dropped by INV_REQ, including the same-cycle push) and STAT_STALLS (cycles with UPD_VALID & ~UPD_READY).
  - All counters reset to 0 and wrap modulo 2^32.
- When undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package bht_pkg holds:
  - the log2 function and the ADDR_WIDTH/HISTORY_DEPTH defaults;
  - TAG_WIDTH/H_ADDR_WIDTH derivation;
  - a packed update record type (pc, target, taken, return);
  - FSM state encodings.
- Sub-module: one, bht_upd_fifo, a generic synchronous FIFO with push, pop, count, full and empty, plus a synchronous clear input for the INV_REQ discard.

Test Plan:
- Reset release with CACHE_READY=1, HISTORY_DEPTH=8 → CLEAR writes at indices 0..7 on 8 consecutive cycles; INV_BUSY drops on the 9th cycle; UPD_READY=1.
- Post-sweep, push PC=0x0000_1004, TARGET=0x0000_2000, TAKEN=1 → next cycle WR_EN=1, IDX=1, TAG=0x0000_1004>>(H_ADDR_WIDTH+2), TARGET=0x2000.
- CACHE_READY=0, push 4 updates → UPD_READY=0 on the 5th attempt. Then raise CACHE_READY → 4 writes in push order on consecutive cycles, and UPD_READY reasserts after the first pop.
- FIFO holding 3 entries, INV_REQ pulse together with a push → no update writes; sweep starts next cycle from index 0; with stats on, STAT_DISCARDS=4.
- Sweep with CACHE_READY toggling 1,0,1,0… → indices advance only on high cycles, none skipped or repeated; INV_REQ mid-sweep restarts at index 0.
- RST asserted mid-drain between clock edges → WR_EN deasserts immediately, count=0, sweep restarts after release.
